lm_sequencer: RTL and testbench

- Load-multiple (LM) register sequencer in the multicycle CPU datapath.
- Sits between the instruction register and the register file / memory address path, downstream of the control unit.
- Consumes the control unit's LM and IW strobes. Walks the register mask of an LM instruction one register per step, supplying the destination register index and the word offset from the stack pointer.
- Returns LMC (load-multiple complete) to the control unit so its FSM leaves the LM loop.

---
 rtl/lm_sequencer_pkg.sv | 25 ++
 rtl/lm_sequencer_if.sv | 35 +++
 rtl/lm_priority_enc.sv | 33 +++
 rtl/lm_sequencer.sv | 87 ++++++++
 tb/tb_lm_sequencer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/lm_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lm_sequencer_pkg
// Shared definitions for the load-multiple (LM) register sequencer:
//   - LM sequencer state encoding (IDLE=0, ARMED=1)
//   - default register-file geometry (NREG / IDXW / OFFW)
//   - position of the register-mask field inside the instruction word
// No ports; imported by the interface and the RTL modules.
// -----------------------------------------------------------------------------
package lm_sequencer_pkg;

  // Register-file geometry covered by an LM mask.
  localparam int LM_NREG = 8;
  localparam int LM_IDXW = 3;   // log2(LM_NREG)
  localparam int LM_OFFW = 4;   // holds 0..LM_NREG, so a full mask never wraps

  // Register-mask field within the instruction word.
  localparam int LM_MASK_LSB = 0;
  localparam int LM_MASK_MSB = LM_MASK_LSB + LM_NREG - 1;

  typedef enum logic {
    LM_IDLE  = 1'b0,  // no instruction captured / nothing pending
    LM_ARMED = 1'b1   // mask captured, at least one register pending
  } lm_state_e;

endpackage

// File: rtl/lm_sequencer_if.sv
// -----------------------------------------------------------------------------
// lm_sequencer_if
// Control-unit <-> LM sequencer signal bundle.
//   master (control unit): drives IW, MaskIn, LM; observes the step outputs
//   slave  (sequencer)   : observes IW, MaskIn, LM; drives LMC, RegIdx,
//                          Offset, Busy, Count
// -----------------------------------------------------------------------------
interface lm_sequencer_if
  import lm_sequencer_pkg::*;
#(
  parameter int NREG = LM_NREG,
  parameter int IDXW = LM_IDXW,
  parameter int OFFW = LM_OFFW
);

  logic            IW;      // instruction write strobe, mask captured
  logic [NREG-1:0] MaskIn;  // register-mask field of the instruction
  logic            LM;      // load-multiple step strobe
  logic            LMC;     // current step is the last (or mask empty)
  logic [IDXW-1:0] RegIdx;  // destination register of the current step
  logic [OFFW-1:0] Offset;  // word offset from SP for the current step
  logic            Busy;    // sequence armed
  logic [OFFW-1:0] Count;   // length of the last completed sequence

  modport master (
    output IW, MaskIn, LM,
    input  LMC, RegIdx, Offset, Busy, Count
  );

  modport slave (
    input  IW, MaskIn, LM,
    output LMC, RegIdx, Offset, Busy, Count
  );

endinterface

// File: rtl/lm_priority_enc.sv
// -----------------------------------------------------------------------------
// lm_priority_enc
// Combinational lowest-set-bit encoder.
//   req    in  N  request vector
//   idx    out W  index of the lowest set bit of req (0 when req == 0)
//   valid  out 1  req has at least one bit set
//   single out 1  req has exactly one bit set
// -----------------------------------------------------------------------------
module lm_priority_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid,
  output logic         single
);

  // Scanning from the top down lets the lowest set bit win the last write.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

  assign valid  = |req;
  // Clearing the lowest set bit leaves zero only if it was the only one.
  assign single = valid && ((req & (req - N'(1))) == '0);

endmodule

// File: rtl/lm_sequencer.sv
// -----------------------------------------------------------------------------
// lm_sequencer
// Load-multiple register sequencer. Captures the register mask on IW and,
// one register per LM cycle, presents the destination register index and the
// word offset from SP. All outputs are decoded from registered state only.
//   CLK      in   system clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   bus      slave modport of lm_sequencer_if (IW, MaskIn, LM in;
//            LMC, RegIdx, Offset, Busy, Count out)
// -----------------------------------------------------------------------------
module lm_sequencer
  import lm_sequencer_pkg::*;
#(
  parameter int NREG = LM_NREG,
  parameter int IDXW = LM_IDXW,
  parameter int OFFW = LM_OFFW
) (
  input  logic          CLK,
  input  logic          Reset_n,
  lm_sequencer_if.slave bus
);

  lm_state_e       state_q, state_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic [OFFW-1:0] offset_q, offset_d;
  logic [OFFW-1:0] count_q, count_d;

  logic [IDXW-1:0] low_idx;
  logic            any_pending;
  logic            last_pending;

  // One encoder serves both the register index and the LMC decode.
  lm_priority_enc #(
    .N (NREG),
    .W (IDXW)
  ) u_enc (
    .req    (pending_q),
    .idx    (low_idx),
    .valid  (any_pending),
    .single (last_pending)
  );

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= LM_IDLE;
      pending_q <= '0;
      offset_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      offset_q  <= offset_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    offset_d  = offset_q;
    count_d   = count_q;

    if (bus.IW) begin
      // A new instruction always wins: it aborts any running sequence and
      // any LM strobe in the same cycle is dropped. Count is left alone.
      pending_d = bus.MaskIn;
      offset_d  = '0;
      state_d   = (bus.MaskIn != '0) ? LM_ARMED : LM_IDLE;
    end else if (state_q == LM_ARMED && bus.LM) begin
      pending_d = pending_q & (pending_q - NREG'(1));
      offset_d  = offset_q + OFFW'(1);
      if (last_pending) begin
        count_d = offset_q + OFFW'(1);
        state_d = LM_IDLE;
      end
    end
  end

  assign bus.RegIdx = low_idx;
  assign bus.LMC    = !any_pending || last_pending;
  assign bus.Busy   = (state_q == LM_ARMED);
  assign bus.Offset = offset_q;
  assign bus.Count  = count_q;

endmodule

// File: tb/tb_lm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lm_sequencer
// Scoreboard bench for lm_sequencer. The driver applies one cycle of
// IW/MaskIn/LM, advances a list-based model of the pending registers and
// queues the expected outputs; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_lm_sequencer;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lm_sequencer_if bus ();

  lm_sequencer dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic [2:0] reg_idx;
    logic [3:0] offset;
    logic       lmc;
    logic       busy;
    logic [3:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: the registers still to transfer, in transfer order.
  int pend_list[$];
  int m_off = 0;
  int m_cnt = 0;

  task automatic model_reset();
    pend_list.delete();
    m_off = 0;
    m_cnt = 0;
  endtask

  task automatic model_load(input logic [7:0] mask);
    pend_list.delete();
    for (int i = 0; i < 8; i++) if (mask[i]) pend_list.push_back(i);
    m_off = 0;
  endtask

  task automatic push_expect(input string name);
    exp_t e;
    e.name    = name;
    e.reg_idx = (pend_list.size() > 0) ? 3'(pend_list[0]) : 3'd0;
    e.offset  = 4'(m_off);
    e.lmc     = (pend_list.size() <= 1);
    e.busy    = (pend_list.size() > 0);
    e.count   = 4'(m_cnt);
    exp_q.push_back(e);
  endtask

  // Called at posedge+1: applies inputs for the coming edge, then models it.
  task automatic cycle(input bit iw, input logic [7:0] mask, input bit lm,
                       input string name);
    bus.IW     = iw;
    bus.MaskIn = mask;
    bus.LM     = lm;
    @(posedge clk);
    if (iw) begin
      model_load(mask);
    end else if (lm && pend_list.size() > 0) begin
      void'(pend_list.pop_front());
      m_off++;
      if (pend_list.size() == 0) m_cnt = m_off;
    end
    #1;
    bus.IW = 1'b0;
    bus.LM = 1'b0;
    push_expect(name);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.RegIdx !== e.reg_idx || bus.Offset !== e.offset ||
            bus.LMC !== e.lmc || bus.Busy !== e.busy || bus.Count !== e.count) begin
          n_fail++;
          $display("FAIL %s: got idx=%0d off=%0d lmc=%b busy=%b cnt=%0d, want idx=%0d off=%0d lmc=%b busy=%b cnt=%0d",
                   e.name, bus.RegIdx, bus.Offset, bus.LMC, bus.Busy, bus.Count,
                   e.reg_idx, e.offset, e.lmc, e.busy, e.count);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.IW     = 1'b0;
    bus.LM     = 1'b0;
    bus.MaskIn = '0;
    rst_n      = 1'b0;
    model_reset();
    #3;
    push_expect("reset");
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Normal sequence: 0,2,5,7 then idle with Count=4.
    cycle(1, 8'b1010_0101, 0, "normal_iw");
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, "normal_step");
    cycle(0, 8'h00, 0, "normal_done");

    // Empty mask: nothing armed, LM has no effect.
    cycle(1, 8'h00, 0, "empty_iw");
    cycle(0, 8'h00, 1, "empty_lm");
    cycle(0, 8'h00, 1, "empty_lm");

    // Full mask: offset climbs to 8 without wrapping.
    cycle(1, 8'hFF, 0, "full_iw");
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, "full_step");
    cycle(0, 8'h00, 1, "full_after");

    // Stall in the middle of a two-register sequence.
    cycle(1, 8'b0001_0010, 0, "stall_iw");
    cycle(0, 8'h00, 1, "stall_step1");
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, "stall_hold");
    cycle(0, 8'h00, 1, "stall_step2");

    // Abort mid-sequence with IW and LM together: IW wins.
    cycle(1, 8'b1010_0101, 0, "abort_iw");
    cycle(0, 8'h00, 1, "abort_step");
    cycle(1, 8'b1000_0000, 1, "abort_reload");
    cycle(0, 8'h00, 1, "abort_finish");

    // Reset pulse between clock edges, mid-sequence.
    cycle(1, 8'b0110_0000, 0, "rst_iw");
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    push_expect("async_reset");
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] m;
      int         sel;
      sel = $urandom_range(0, 7);
      m   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      cycle($urandom_range(0, 9) == 0, m, $urandom_range(0, 3) != 0, "random");
    end

    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
